// File: rtl/shiftreg_n.sv
// N-stage, data_width-wide delay line with per-stage valid tracking and an occupancy counter.
// Optional run-time read tap is enabled by defining SHIFTREG_N_TAP_EN.
module shiftreg_n #(
    parameter  int data_width = 25,
    parameter  int DEPTH      = 4,
    localparam int CW         = $clog2(DEPTH + 1),
    localparam int TW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  write_valid,
    input  logic [data_width-1:0] write_data,
    output logic [data_width-1:0] read_data,
    output logic                  read_valid,
    output logic [CW-1:0]         fill_count,
    output logic                  full,
    output logic                  empty,
    input  logic [TW-1:0]         tap_sel,
    output logic [data_width-1:0] tap_data,
    output logic                  tap_valid
);

    logic [data_width-1:0] stage_q [DEPTH];
    logic [data_width-1:0] stage_d [DEPTH];
    logic [DEPTH-1:0]      valid_q;
    logic [DEPTH-1:0]      valid_d;
    logic [CW-1:0]         fill_count_q;
    logic [CW-1:0]         fill_count_d;

    always_comb begin
        // NOTE: every *_d is given its hold value first so no branch can infer a latch.
        stage_d      = stage_q;
        valid_d      = valid_q;
        fill_count_d = fill_count_q;
        if (enable && clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_d[i] = '0;
            end
            valid_d      = '0;
            fill_count_d = '0;
        end else if (enable) begin
            stage_d[0] = write_data;
            valid_d[0] = write_valid;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
                valid_d[i] = valid_q[i-1];
            end
            // Modular arithmetic keeps this exact even when the +1 briefly overflows CW bits.
            fill_count_d = fill_count_q + CW'(write_valid) - CW'(valid_q[DEPTH-1]);
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: the data stages are reset as well, so read_data and tap_data read 0 out of reset.
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
            valid_q      <= '0;
            fill_count_q <= '0;
        end else begin
            // NOTE: non-blocking updates let every stage sample its neighbour's pre-edge value.
            stage_q      <= stage_d;
            valid_q      <= valid_d;
            fill_count_q <= fill_count_d;
        end
    end

    assign read_data  = stage_q[DEPTH-1];
    assign read_valid = valid_q[DEPTH-1];
    assign fill_count = fill_count_q;
    assign full       = (fill_count_q == CW'(DEPTH));
    assign empty      = (fill_count_q == '0);

    // tap_sel has no effect when the tap is compiled out or DEPTH is 1.
    logic unused_tap_sel;
    assign unused_tap_sel = ^tap_sel;

`ifdef SHIFTREG_N_TAP_EN
    always_comb begin
        tap_data  = '0;
        tap_valid = 1'b0;
        if (DEPTH == 1) begin
            tap_data  = stage_q[0];
            tap_valid = valid_q[0];
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (tap_sel == TW'(i)) begin
                    tap_data  = stage_q[i];
                    tap_valid = valid_q[i];
                end
            end
        end
    end
`else
    assign tap_data  = '0;
    assign tap_valid = 1'b0;
`endif

`ifndef SYNTHESIS
    fill_matches_popcount: assert property (@(posedge clock)
        $countones(valid_q) == int'(fill_count_q));
`endif

endmodule

// File: tb/tb_shiftreg_n.sv
// Self-checking bench for shiftreg_n: DEPTH=4/25b, DEPTH=1/25b and DEPTH=4/16b instances
// share one stimulus stream and are compared every cycle against a queue-based model.
module tb_shiftreg_n;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic        write_valid = 1'b0;
    logic [24:0] write_data = '0;
    logic [1:0]  tap_sel = '0;

    logic [24:0] a_rd, a_td;
    logic        a_rv, a_full, a_empty, a_tv;
    logic [2:0]  a_fc;
    logic [24:0] b_rd, b_td;
    logic        b_rv, b_full, b_empty, b_tv;
    logic [0:0]  b_fc;
    logic [15:0] c_rd, c_td;
    logic        c_rv, c_full, c_empty, c_tv;
    logic [2:0]  c_fc;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    shiftreg_n #(.data_width(25), .DEPTH(4)) u_a (
        .clock(clk), .reset(reset), .enable(enable), .clear(clear),
        .write_valid(write_valid), .write_data(write_data),
        .read_data(a_rd), .read_valid(a_rv), .fill_count(a_fc),
        .full(a_full), .empty(a_empty),
        .tap_sel(tap_sel), .tap_data(a_td), .tap_valid(a_tv)
    );

    shiftreg_n #(.data_width(25), .DEPTH(1)) u_b (
        .clock(clk), .reset(reset), .enable(enable), .clear(clear),
        .write_valid(write_valid), .write_data(write_data),
        .read_data(b_rd), .read_valid(b_rv), .fill_count(b_fc),
        .full(b_full), .empty(b_empty),
        .tap_sel(tap_sel[0]), .tap_data(b_td), .tap_valid(b_tv)
    );

    shiftreg_n #(.data_width(16), .DEPTH(4)) u_c (
        .clock(clk), .reset(reset), .enable(enable), .clear(clear),
        .write_valid(write_valid), .write_data(write_data[15:0]),
        .read_data(c_rd), .read_valid(c_rv), .fill_count(c_fc),
        .full(c_full), .empty(c_empty),
        .tap_sel(tap_sel), .tap_data(c_td), .tap_valid(c_tv)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: each instance is a window of its last DEPTH accepted words, newest at index 0.
    typedef struct packed {
        logic        v;
        logic [31:0] d;
    } ent_t;

    ent_t        mq [3][$];
    int          md [3] = '{4, 1, 4};
    logic [31:0] mk [3] = '{32'h1FF_FFFF, 32'h1FF_FFFF, 32'h0000_FFFF};
    logic        checking = 1'b0;

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (reset || (enable && clear)) begin
                mq[k].delete();
                for (int i = 0; i < md[k]; i++) mq[k].push_back('{1'b0, 32'd0});
            end else if (enable) begin
                ent_t e;
                e.v = write_valid;
                e.d = 32'(write_data) & mk[k];
                mq[k].push_front(e);
                void'(mq[k].pop_back());
            end
        end
        if (reset) checking = 1'b1;
    end

    task automatic cmp_inst(input int k, input logic [31:0] rd, input logic [31:0] rv,
                            input logic [31:0] fc, input logic [31:0] fu, input logic [31:0] em,
                            input logic [31:0] td, input logic [31:0] tv, input int ts);
        int   cnt;
        int   idx;
        ent_t tap_e;
        cnt = 0;
        for (int i = 0; i < md[k]; i++) cnt += int'(mq[k][i].v);
        check($sformatf("i%0d_read_data", k),  rd, mq[k][md[k]-1].d);
        check($sformatf("i%0d_read_valid", k), rv, 32'(mq[k][md[k]-1].v));
        check($sformatf("i%0d_fill_count", k), fc, 32'(cnt));
        check($sformatf("i%0d_full", k),       fu, 32'(cnt == md[k]));
        check($sformatf("i%0d_empty", k),      em, 32'(cnt == 0));
        tap_e = '{1'b0, 32'd0};
`ifdef SHIFTREG_N_TAP_EN
        idx = (md[k] == 1) ? 0 : ts;
        if (idx < md[k]) tap_e = mq[k][idx];
`else
        idx = ts;
`endif
        check($sformatf("i%0d_tap_data(sel%0d)", k, idx), td, tap_e.d);
        check($sformatf("i%0d_tap_valid(sel%0d)", k, idx), tv, 32'(tap_e.v));
    endtask

    always @(negedge clk) begin
        if (checking) begin
            cmp_inst(0, 32'(a_rd), 32'(a_rv), 32'(a_fc), 32'(a_full), 32'(a_empty),
                     32'(a_td), 32'(a_tv), int'(tap_sel));
            cmp_inst(1, 32'(b_rd), 32'(b_rv), 32'(b_fc), 32'(b_full), 32'(b_empty),
                     32'(b_td), 32'(b_tv), int'(tap_sel[0]));
            cmp_inst(2, 32'(c_rd), 32'(c_rv), 32'(c_fc), 32'(c_full), 32'(c_empty),
                     32'(c_td), 32'(c_tv), int'(tap_sel));
        end
    end

    // Apply inputs, let one rising edge take them, return 1 time unit after that edge.
    task automatic cyc(input logic rs, input logic en, input logic cl, input logic wv,
                       input logic [24:0] wd);
        reset       = rs;
        enable      = en;
        clear       = cl;
        write_valid = wv;
        write_data  = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_read_data"}, 32'(a_rd), 32'h0);
        check({tag, "_read_valid"}, 32'(a_rv), 32'h0);
        check({tag, "_fill_count"}, 32'(a_fc), 32'h0);
        check({tag, "_empty"}, 32'(a_empty), 32'h1);
        check({tag, "_full"}, 32'(a_full), 32'h0);
    endtask

    initial begin
        cyc(1, 1, 0, 0, 25'h0);
        cyc(1, 1, 0, 0, 25'h0);
        check_idle("por");

        // Latency: word k reaches read_data on the 4th enabled edge after it is written.
        for (int i = 1; i <= 6; i++) begin
            cyc(0, 1, 0, 1, 25'(i));
            if (i == 1) begin
                check("d1_read_data", 32'(b_rd), 32'h1);
                check("d1_read_valid", 32'(b_rv), 32'h1);
            end
            if (i < 4) check($sformatf("lat_rv_e%0d", i), 32'(a_rv), 32'h0);
            else begin
                check($sformatf("lat_rd_e%0d", i), 32'(a_rd), 32'(i - 3));
                check($sformatf("lat_rv_e%0d", i), 32'(a_rv), 32'h1);
            end
            check($sformatf("lat_fc_e%0d", i), 32'(a_fc), 32'((i < 4) ? i : 4));
        end

        // Reset mid-stream, two cycles, with enable and write_valid high.
        cyc(1, 1, 0, 1, 25'h77);
        cyc(1, 1, 0, 1, 25'h77);
        check_idle("midrst");

        // Stall: enable=0 cycles must not count towards latency.
        cyc(0, 1, 0, 1, 25'hA);
        cyc(0, 1, 0, 1, 25'hB);
        check("stall_fc_pre", 32'(a_fc), 32'h2);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 25'hEE);
            check($sformatf("stall_fc_%0d", i), 32'(a_fc), 32'h2);
            check($sformatf("stall_rv_%0d", i), 32'(a_rv), 32'h0);
        end
        cyc(0, 1, 0, 1, 25'hC);
        check("stall_fc_c", 32'(a_fc), 32'h3);
        check("stall_rv_c", 32'(a_rv), 32'h0);
        cyc(0, 1, 0, 1, 25'hD);
        check("stall_rd_a", 32'(a_rd), 32'hA);
        check("stall_rv_a", 32'(a_rv), 32'h1);
        check("stall_full", 32'(a_full), 32'h1);

        // Occupancy: saturate at DEPTH, then drain with invalid writes.
        cyc(1, 0, 0, 0, 25'h0);
        for (int i = 1; i <= 5; i++) begin
            cyc(0, 1, 0, 1, 25'(32'h100 + i));
            check($sformatf("occ_fc_up%0d", i), 32'(a_fc), 32'((i < 4) ? i : 4));
            check($sformatf("occ_full_up%0d", i), 32'(a_full), 32'(i >= 4));
        end
        for (int i = 1; i <= 4; i++) begin
            cyc(0, 1, 0, 0, 25'h0);
            check($sformatf("occ_fc_dn%0d", i), 32'(a_fc), 32'(4 - i));
        end
        check("occ_empty", 32'(a_empty), 32'h1);

        // Tap and clear.
        cyc(1, 0, 0, 0, 25'h0);
        cyc(0, 1, 0, 1, 25'h11);
        cyc(0, 1, 0, 1, 25'h22);
        cyc(0, 1, 0, 1, 25'h33);
        check("clr_fc_fill", 32'(a_fc), 32'h3);
        tap_sel = 2'd2;
        cyc(0, 0, 0, 0, 25'h0);
`ifdef SHIFTREG_N_TAP_EN
        check("tap2_data", 32'(a_td), 32'h11);
        check("tap2_valid", 32'(a_tv), 32'h1);
`else
        check("tap2_data", 32'(a_td), 32'h0);
        check("tap2_valid", 32'(a_tv), 32'h0);
`endif
        tap_sel = 2'd3;
        cyc(0, 0, 0, 0, 25'h0);
        check("tap3_data", 32'(a_td), 32'h0);
        check("tap3_valid", 32'(a_tv), 32'h0);
        tap_sel = 2'd1;
        cyc(0, 0, 1, 1, 25'h99);
        check("clr_noen_fc", 32'(a_fc), 32'h3);
`ifdef SHIFTREG_N_TAP_EN
        check("tap1_data", 32'(a_td), 32'h22);
`else
        check("tap1_data", 32'(a_td), 32'h0);
`endif
        cyc(0, 1, 1, 1, 25'h55);
        check_idle("clr");
        check("clr_tap_valid", 32'(a_tv), 32'h0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 0, 25'h0);
            check($sformatf("clr_nocap_rd%0d", i), 32'(a_rd), 32'h0);
            check($sformatf("clr_nocap_rv%0d", i), 32'(a_rv), 32'h0);
        end

        // Mixed traffic, checked by the per-cycle model only.
        for (int i = 0; i < 48; i++) begin
            tap_sel = 2'(i % 4);
            cyc(logic'(i == 30), logic'(i % 3 != 2), logic'(i == 20), logic'(i % 4 != 3),
                25'(i * 32'h2B3C5 + 1));
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
